arithunit: RTL and testbench
============================

ARITHUNIT -- requirements
Module: arithunit

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; all widths below follow it.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: D  output  WIDTH  registered arithmetic result.
REQ-005 Port: C_out  output  1  registered carry out of the result MSB.
REQ-006 Port: z  output  1  registered zero flag; 1 when D is all zeros.
REQ-007 Port: A  input  WIDTH  operand A, unsigned.
REQ-008 Port: B  input  WIDTH  operand B, unsigned.
REQ-009 Port: s1  input  1  operation select, high bit.
REQ-010 Port: s0  input  1  operation select, low bit.
REQ-011 Port: C_in  input  1  carry in, added to every operation.
REQ-012 Positional port order SHALL be clk, rst_n, D, C_out, z, A, B, s1, s0, C_in.

Function
REQ-013 Core SHALL compute {C_out,D} = A + Y + C_in as a WIDTH+1-bit unsigned sum, with Y selected by {s1,s0}.
REQ-014 {s1,s0}=00: Y = 0 (transfer / increment A).
REQ-015 {s1,s0}=01: Y = B (add).
REQ-016 {s1,s0}=10: Y = ~B (subtract with borrow; C_in=1 gives A-B).
REQ-017 {s1,s0}=11: Y = all ones (decrement A; C_in=1 gives transfer A).
REQ-018 D SHALL be the low WIDTH bits of the sum; C_out SHALL be bit WIDTH; overflow wraps modulo 2^WIDTH.
REQ-019 z SHALL be computed from the new D value and registered in the same cycle as D.
REQ-020 A, B, s1, s0, C_in SHALL be sampled on each rising clk edge; D, C_out, z SHALL reflect them after exactly one cycle latency.
REQ-021 No enable or handshake; a new result SHALL be registered every cycle.
REQ-022 Subtract: C_out=1 SHALL mean A >= B when C_in=1 (no borrow).
REQ-023 Decrement: C_out SHALL be 0 only when A=0 and C_in=0.

Reset
REQ-024 rst_n low SHALL immediately force D=0, C_out=0, z=1, independent of clk.
REQ-025 Release of rst_n SHALL take effect at the next rising clk edge; the first post-reset result SHALL appear one cycle after that edge.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; no partial update.

Structure
REQ-027 Shared package arithunit_pkg SHALL hold WIDTH default and the four select encodings (OP_TRANSFER=00, OP_ADD=01, OP_SUB=10, OP_DEC=11).
REQ-028 One sub-module arith_adder SHALL implement the WIDTH-bit ripple-carry add (A, Y, C_in -> sum, carry); B-input mux, zero detect and output registers SHALL live in arithunit.

Verification
REQ-029 A=35, B=25, C_in=0 with {s1,s0}=00/01/10/11 -> D=35/60/9/34, C_out=0/0/1/1, z=0, each one cycle after the input.
REQ-030 A=35, B=25, C_in=1 with {s1,s0}=00/01/10/11 -> D=36/61/10/35, C_out=0/0/1/1, z=0.
REQ-031 A=B=77, {s1,s0}=10, C_in=1 -> D=0, C_out=1, z=1; A=255, B=1, {s1,s0}=01, C_in=0 -> D=0, C_out=1, z=1.
REQ-032 A=0, {s1,s0}=11, C_in=0 -> D=255, C_out=0, z=0; A=10, B=20, {s1,s0}=10, C_in=1 -> D=246, C_out=0.
REQ-033 Drive rst_n low between clock edges while D=61 -> D=0, C_out=0, z=1 immediately; after release, the first edge registers the current inputs and the result appears one cycle later.
REQ-034 Randomised back-to-back inputs every cycle -> each output equals the REQ-013 reference model of the inputs from the previous cycle.

Source files
------------

// File: rtl/arithunit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arithunit_pkg
//  Description : Shared width default and operation-select encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package arithunit_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] OP_TRANSFER = 2'b00;
  localparam logic [1:0] OP_ADD      = 2'b01;
  localparam logic [1:0] OP_SUB      = 2'b10;
  localparam logic [1:0] OP_DEC      = 2'b11;

endpackage : arithunit_pkg
`default_nettype wire

// File: rtl/arith_adder.sv
`default_nettype none
// ============================================================================
//  Module      : arith_adder
//  Description : WIDTH-bit ripple-carry adder, sum and carry out of the MSB.
//  Revision    : 1.0  initial release
// ============================================================================
module arith_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_c;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
      assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  endgenerate

  assign o_carry = w_carry[WIDTH];

endmodule : arith_adder
`default_nettype wire

// File: rtl/arithunit.sv
`default_nettype none
// ============================================================================
//  Module      : arithunit
//  Description : Registered A + Y + C_in unit; Y is 0, B, ~B or all ones.
//  Revision    : 1.0  initial release
// ============================================================================
module arithunit
  import arithunit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] D,
  output logic             C_out,
  output logic             z,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             s1,
  input  logic             s0,
  input  logic             C_in
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_zero;

  logic [WIDTH-1:0] r_d;
  logic             r_c_out;
  logic             r_z;

  always_comb begin
    w_y = '0;
    case ({s1, s0})
      OP_TRANSFER: w_y = '0;
      OP_ADD:      w_y = B;
      OP_SUB:      w_y = ~B;
      OP_DEC:      w_y = '1;
      default:     w_y = '0;
    endcase
  end

  arith_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a     (A),
    .i_b     (w_y),
    .i_c     (C_in),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Zero flag derives from the new sum so it lands in the same cycle as D.
  assign w_zero = (w_sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d     <= '0;
      r_c_out <= 1'b0;
      r_z     <= 1'b1;
    end else begin
      r_d     <= w_sum;
      r_c_out <= w_carry;
      r_z     <= w_zero;
    end
  end

  assign D     = r_d;
  assign C_out = r_c_out;
  assign z     = r_z;

endmodule : arithunit
`default_nettype wire

// File: tb/tb_arithunit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arithunit
//  Description : Directed and random self-checking bench for arithunit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arithunit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] D;
  logic             C_out;
  logic             z;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             s1;
  logic             s0;
  logic             C_in;

  int n_vec;
  int n_err;

  arithunit #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .C_out (C_out),
    .z     (z),
    .A     (A),
    .B     (B),
    .s1    (s1),
    .s0    (s0),
    .C_in  (C_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word is {C_out, z, D}.
  task automatic chk(input string tag, input logic [WIDTH+1:0] exp);
    logic [WIDTH+1:0] obs;
    obs = {C_out, z, D};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed C_out=%b z=%b D=%0d expected C_out=%b z=%b D=%0d",
             tag, obs[WIDTH+1], obs[WIDTH], obs[WIDTH-1:0],
             exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] sel, input logic cin);
    @(negedge clk);
    A    = a;
    B    = b;
    {s1, s0} = sel;
    C_in = cin;
  endtask

  task automatic step(input string tag, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [1:0] sel,
                      input logic cin, input logic c, input logic zf,
                      input logic [WIDTH-1:0] d);
    drive(a, b, sel, cin);
    @(posedge clk);
    #1;
    chk(tag, {c, zf, d});
  endtask

  initial begin
    logic [WIDTH:0]   ref_sum;
    logic [WIDTH-1:0] ref_y;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [1:0]       rs;
    logic             rc;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    A = '0; B = '0; s1 = 1'b0; s0 = 1'b0; C_in = 1'b0;

    #1 rst_n = 1'b0;
    #1 chk("reset_async", {1'b0, 1'b1, 8'd0});

    @(posedge clk); #1;
    chk("reset_held", {1'b0, 1'b1, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;

    step("xfer_c0", 8'd35, 8'd25, 2'b00, 1'b0, 1'b0, 1'b0, 8'd35);
    step("add_c0",  8'd35, 8'd25, 2'b01, 1'b0, 1'b0, 1'b0, 8'd60);
    step("sub_c0",  8'd35, 8'd25, 2'b10, 1'b0, 1'b1, 1'b0, 8'd9);
    step("dec_c0",  8'd35, 8'd25, 2'b11, 1'b0, 1'b1, 1'b0, 8'd34);
    step("xfer_c1", 8'd35, 8'd25, 2'b00, 1'b1, 1'b0, 1'b0, 8'd36);
    step("add_c1",  8'd35, 8'd25, 2'b01, 1'b1, 1'b0, 1'b0, 8'd61);
    step("sub_c1",  8'd35, 8'd25, 2'b10, 1'b1, 1'b1, 1'b0, 8'd10);
    step("dec_c1",  8'd35, 8'd25, 2'b11, 1'b1, 1'b1, 1'b0, 8'd35);
    step("sub_eq",  8'd77, 8'd77, 2'b10, 1'b1, 1'b1, 1'b1, 8'd0);
    step("add_wrap",8'd255,8'd1,  2'b01, 1'b0, 1'b1, 1'b1, 8'd0);
    step("dec_zero",8'd0,  8'd0,  2'b11, 1'b0, 1'b0, 1'b0, 8'd255);
    step("sub_brw", 8'd10, 8'd20, 2'b10, 1'b1, 1'b0, 1'b0, 8'd246);

    // New inputs must not show until the next rising edge.
    drive(8'd1, 8'd2, 2'b01, 1'b0);
    #1 chk("latency_hold", {1'b0, 1'b0, 8'd246});
    @(posedge clk); #1;
    chk("latency_update", {1'b0, 1'b0, 8'd3});

    // Mid-stream reset with D=61 showing, next inputs already in flight.
    step("pre_reset", 8'd35, 8'd25, 2'b01, 1'b1, 1'b0, 1'b0, 8'd61);
    drive(8'd100, 8'd50, 2'b01, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid", {1'b0, 1'b1, 8'd0});
    @(posedge clk); #1;
    chk("reset_mid_edge", {1'b0, 1'b1, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_release", {1'b0, 1'b1, 8'd0});
    @(posedge clk); #1;
    chk("post_reset", {1'b0, 1'b0, 8'd150});

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      rs = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      if (rs == 2'b00)      ref_y = 8'd0;
      else if (rs == 2'b01) ref_y = rb;
      else if (rs == 2'b10) ref_y = 8'd255 - rb;
      else                  ref_y = 8'd255;
      ref_sum = {1'b0, ra} + {1'b0, ref_y} + {8'd0, rc};
      step("random", ra, rb, rs, rc, ref_sum[WIDTH],
           (ref_sum[WIDTH-1:0] == 8'd0), ref_sum[WIDTH-1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_arithunit
`default_nettype wire
